contador_mod_updown: RTL
========================

Name: contador_mod_updown

Overview:
- Parametrised successor to the basic enable counter: N-bit up/down counter with runtime-programmable modulus, synchronous clear and load, and wrap or saturate mode.
- Registered terminal-count pulse for cascading digits, as in clock/timer displays.
- Sits in timing/prescaler paths and feeds display or FSM logic directly from registered outputs.

Parameters:
- N, 8, counter width in bits (N >= 2).
- SAT, 0, boundary mode: 0 = wrap-around, 1 = saturate at boundary.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset: clears all state while low.
- en  input  1  count enable, sampled on the rising clk edge.
- up  input  1  direction: 1 = count up, 0 = count down.
- clr  input  1  synchronous clear to 0.
- ld  input  1  synchronous load of d.
- d  input  N  load value.
- max  input  N  top count value (modulus − 1). Sampled every cycle; may change at runtime.
- q  output  N  current count (register output).
- tc  output  1  terminal-count flag, registered.

Behaviour:
- Reset (reset = 0, asynchronous): q = 0 and tc = 0 immediately. Both are held while reset is low. The first update occurs on the first rising clk edge after reset goes high.
- Per-edge priority: clr > ld > en > hold.
- clr = 1: q <= 0, tc <= 0.
- ld = 1: q <= d if d <= max, else q <= max (clamped). tc <= 0.
- en = 1, up = 1:
  - if q < max: q <= q + 1, tc <= 0.
  - if q >= max (boundary): SAT = 0 → q <= 0; SAT = 1 → q <= max. tc <= 1 in both cases.
- en = 1, up = 0:
  - if q == 0 (boundary): SAT = 0 → q <= max; SAT = 1 → q <= 0. tc <= 1.
  - if q > max: q <= max, tc <= 0.
  - otherwise: q <= q − 1, tc <= 0.
- en = 0 (no clr/ld): q holds, tc <= 0.
- tc pulse rules:
  - tc is high for exactly the cycle after an enabled boundary step.
  - SAT = 1: tc stays high on every consecutive enabled cycle while the counter sits at the boundary.
  - SAT = 0 with max = 0: tc is high on every enabled cycle.
- Latency: one clock from any control input to q/tc. There are no combinational paths from inputs to outputs.
- Width rules:
  - Arithmetic is N bits; there is no carry-out beyond tc.
  - With max = 2^N − 1, wrap behaves as natural binary overflow.
- max lowered below the current q:
  - counting up: the next enabled edge is treated as a boundary.
  - counting down: the next enabled edge clamps q to max.
- up toggled mid-count: takes effect on the same edge it is sampled. No extra state.
- Reset asserted mid-count: q and tc are cleared asynchronously; no partial update.

Test Plan:
- Reset and enable: N = 8, SAT = 0, max = 9, en = 1, up = 1 → q steps 0..9 then back to 0. tc = 1 only in the cycle when q = 0 after 9. Drop reset mid-count at q = 5 → q = 0 and tc = 0 before the next edge.
- Down wrap: max = 9, up = 0, start q = 0 → next q = 9 with tc = 1, then 8, 7, … with tc = 0.
- Saturate: SAT = 1, max = 5, up = 1 from q = 3 → 4, 5, 5, 5 with tc = 0, 0, 1, 1. Then up = 0 from 5 down to 0, then held at 0 with tc = 1 each enabled cycle.
- Load and clear priority:
  - ld = 1, d = 7, max = 9 → q = 7.
  - ld = 1, d = 12 → q = 9 (clamped).
  - ld = 1 and clr = 1 together → q = 0.
  - ld = 1 and en = 1 together → q = d, no increment.
- Runtime max change: q = 8, max changed to 4, up = 1 → next q = 0 with tc = 1. Repeat with up = 0 → next q = 4 with tc = 0.
- Full-range wrap: max = 255, q = 255, up = 1 → q = 0 with tc = 1. With en = 0 for 3 cycles, q holds and tc = 0.

Source files
------------

// File: rtl/contador_mod_updown.sv
// contador_mod_updown: N-bit up/down counter with runtime modulus, sync clear/load,
// wrap or saturate boundary mode, and a registered terminal-count pulse.
module contador_mod_updown #(
  parameter int unsigned N   = 8,
  parameter bit          SAT = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         up,
  input  logic         clr,
  input  logic         ld,
  input  logic [N-1:0] d,
  input  logic [N-1:0] max,
  output logic [N-1:0] q,
  output logic         tc
);

  localparam logic [N-1:0] ONE  = N'(1);
  localparam logic [N-1:0] ZERO = N'(0);

  logic [N-1:0] r_q;
  logic         r_tc;
  logic [N-1:0] w_q_nxt;
  logic         w_tc_nxt;
  logic [N-1:0] w_ld_val;

  // Load value clamped to the current top count
  assign w_ld_val = (d > max) ? max : d;

  // Next count and terminal flag; priority clr > ld > en > hold
  always_comb begin
    w_q_nxt  = r_q;
    w_tc_nxt = 1'b0;
    if (clr) begin
      w_q_nxt = ZERO;
    end else if (ld) begin
      w_q_nxt = w_ld_val;
    end else if (en) begin
      if (up) begin
        if (r_q < max) begin
          w_q_nxt = r_q + ONE;
        end else begin
          // At or above top (max may have dropped below q): boundary step
          w_q_nxt  = SAT ? max : ZERO;
          w_tc_nxt = 1'b1;
        end
      end else begin
        if (r_q == ZERO) begin
          w_q_nxt  = SAT ? ZERO : max;
          w_tc_nxt = 1'b1;
        end else if (r_q > max) begin
          // Top lowered below q while counting down: clamp, no pulse
          w_q_nxt = max;
        end else begin
          w_q_nxt = r_q - ONE;
        end
      end
    end
  end

  // Count and terminal-count registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q  <= ZERO;
      r_tc <= 1'b0;
    end else begin
      r_q  <= w_q_nxt;
      r_tc <= w_tc_nxt;
    end
  end

  assign q  = r_q;
  assign tc = r_tc;

endmodule
